sal_dram_sched: RTL

//  Channel command scheduler between NUM_BANKS per-bank controllers and the DDR2 command bus.
//  - Each cycle, selects at most one ACT/RD/WR/PRE/REF request and returns a same-cycle grant.
//  - Enforces inter-bank timing: tRRD, tCCD, tWTR, tRTW. Per-bank timing stays in the bank controllers.
//  - Drives a registered command/bank/address output toward the PHY.

---
 rtl/sal_sched_pkg.sv | 15 +
 rtl/sal_rr_arb.sv | 31 +++
 rtl/sal_timing_cnt.sv | 26 ++
 rtl/sal_dram_sched.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
// Shared types and defaults for the DDR2 channel command scheduler.
package sal_sched_pkg;

    localparam int TW = 4;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } sal_cmd_e;

endpackage

// File: rtl/sal_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module sal_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sal_timing_cnt.sv
// Saturating down-counter for one inter-command timing constraint.
module sal_timing_cnt #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reset_cmd,
    input  logic [TW-1:0] reset_value,
    output logic          is_zero
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reset_cmd) begin
            cnt <= reset_value;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_dram_sched.sv
// Channel command scheduler: picks one bank request per cycle under inter-bank
// timing (tRRD/tCCD/tWTR/tRTW) and registers the chosen command toward the PHY.
module sal_dram_sched #(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = $clog2(NUM_BANKS),
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = sal_sched_pkg::TW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS-1:0]          act_req_i,
    input  logic [NUM_BANKS-1:0]          rd_req_i,
    input  logic [NUM_BANKS-1:0]          wr_req_i,
    input  logic [NUM_BANKS-1:0]          pre_req_i,
    input  logic [NUM_BANKS-1:0]          ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
    output logic [NUM_BANKS-1:0]          act_gnt_o,
    output logic [NUM_BANKS-1:0]          rd_gnt_o,
    output logic [NUM_BANKS-1:0]          wr_gnt_o,
    output logic [NUM_BANKS-1:0]          pre_gnt_o,
    output logic [NUM_BANKS-1:0]          ref_gnt_o,
    input  logic [TW-1:0]                 t_rrd_i,
    input  logic [TW-1:0]                 t_ccd_i,
    input  logic [TW-1:0]                 t_wtr_i,
    input  logic [TW-1:0]                 t_rtw_i,
    output logic [2:0]                    cmd_o,
    output logic [BA_WIDTH-1:0]           ba_o,
    output logic [RA_WIDTH-1:0]           addr_o
);

    import sal_sched_pkg::*;

    logic [BA_WIDTH-1:0]  ptr;
    logic                 rrd_ok, ccd_ok, wtr_ok, rtw_ok;
    logic [NUM_BANKS-1:0] act_elig, rd_elig, wr_elig, cas_elig;
    logic [NUM_BANKS-1:0] ref_sel, pre_sel, cas_sel, act_sel;
    logic [BA_WIDTH-1:0]  ref_idx, pre_idx, cas_idx, act_idx;
    sal_cmd_e             cmd_p0;
    logic [BA_WIDTH-1:0]  ba_p0;
    logic [RA_WIDTH-1:0]  addr_p0;

    // Counter holds t-1 so that a zero count means "met"; t of 0 or 1 allows back to back.
    function automatic logic [TW-1:0] load_val(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // RD and WR share one arbiter; each request is pre-qualified by its own gates.
    assign rd_elig  = rd_req_i  & {NUM_BANKS{ccd_ok & wtr_ok}};
    assign wr_elig  = wr_req_i  & {NUM_BANKS{ccd_ok & rtw_ok}};
    assign cas_elig = rd_elig | wr_elig;
    assign act_elig = act_req_i & {NUM_BANKS{rrd_ok}};

    sal_rr_arb #(.N(NUM_BANKS)) u_ref_arb (.req(ref_req_i), .ptr(ptr), .gnt(ref_sel), .idx(ref_idx));
    sal_rr_arb #(.N(NUM_BANKS)) u_pre_arb (.req(pre_req_i), .ptr(ptr), .gnt(pre_sel), .idx(pre_idx));
    sal_rr_arb #(.N(NUM_BANKS)) u_cas_arb (.req(cas_elig),  .ptr(ptr), .gnt(cas_sel), .idx(cas_idx));
    sal_rr_arb #(.N(NUM_BANKS)) u_act_arb (.req(act_elig),  .ptr(ptr), .gnt(act_sel), .idx(act_idx));

    // Stage p0: class priority REF > PRE > CAS > ACT; a bank with RD and WR both eligible gets RD.
    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        cmd_p0    = NOP;
        ba_p0     = '0;
        addr_p0   = '0;
        if (rst_n) begin
            if (|ref_req_i) begin
                ref_gnt_o = ref_sel;
                cmd_p0    = REF;
                ba_p0     = ref_idx;
            end else if (|pre_req_i) begin
                pre_gnt_o = pre_sel;
                cmd_p0    = PRE;
                ba_p0     = pre_idx;
            end else if (|cas_elig) begin
                ba_p0   = cas_idx;
                addr_p0 = RA_WIDTH'(ca_i[int'(cas_idx)*CA_WIDTH +: CA_WIDTH]);
                if (rd_elig[cas_idx]) begin
                    rd_gnt_o = cas_sel;
                    cmd_p0   = RD;
                end else begin
                    wr_gnt_o = cas_sel;
                    cmd_p0   = WR;
                end
            end else if (|act_elig) begin
                act_gnt_o = act_sel;
                cmd_p0    = ACT;
                ba_p0     = act_idx;
                addr_p0   = ra_i[int'(act_idx)*RA_WIDTH +: RA_WIDTH];
            end
        end
    end

    sal_timing_cnt #(.TW(TW)) u_rrd (.clk(clk), .rst_n(rst_n), .reset_cmd(cmd_p0 == ACT),
                                     .reset_value(load_val(t_rrd_i)), .is_zero(rrd_ok));
    sal_timing_cnt #(.TW(TW)) u_ccd (.clk(clk), .rst_n(rst_n), .reset_cmd(cmd_p0 == RD || cmd_p0 == WR),
                                     .reset_value(load_val(t_ccd_i)), .is_zero(ccd_ok));
    sal_timing_cnt #(.TW(TW)) u_wtr (.clk(clk), .rst_n(rst_n), .reset_cmd(cmd_p0 == WR),
                                     .reset_value(load_val(t_wtr_i)), .is_zero(wtr_ok));
    sal_timing_cnt #(.TW(TW)) u_rtw (.clk(clk), .rst_n(rst_n), .reset_cmd(cmd_p0 == RD),
                                     .reset_value(load_val(t_rtw_i)), .is_zero(rtw_ok));

    // Stage p1: registered command toward the PHY; ptr wraps naturally as NUM_BANKS is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_o  <= NOP;
            ba_o   <= '0;
            addr_o <= '0;
            ptr    <= '0;
        end else begin
            cmd_o  <= cmd_p0;
            ba_o   <= ba_p0;
            addr_o <= addr_p0;
            if (cmd_p0 != NOP) begin
                ptr <= ba_p0 + BA_WIDTH'(1);
            end
        end
    end

endmodule
